// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and the id-width helper for the FIFO write arbiter.
package fifo_arb_pkg;

   // Arbiter control state: waiting for a request, or holding a grant for a packet.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int DEF_SRC_W  = 8;
   localparam int DEF_DST_W  = 8;
   localparam int DEF_DATA_W = 32;

   // Number of bits needed to index n items (bounded loop so it elaborates as a constant).
   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake bus and FIFO write port of the shared-FIFO write arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/FIFO side.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int SRC_W  = DEF_SRC_W,
   parameter int DST_W  = DEF_DST_W,
   parameter int DATA_W = DEF_DATA_W
);
   localparam int ID_W = clog2(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_last;
   logic [NREQ*SRC_W-1:0]  req_src;
   logic [NREQ*DST_W-1:0]  req_dst;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   fifo_fullp;
   logic                   fifo_writep;
   logic [SRC_W-1:0]       fifo_src;
   logic [DST_W-1:0]       fifo_dst;
   logic [DATA_W-1:0]      fifo_data;
   logic                   grant_vld;
   logic [ID_W-1:0]        grant_id;
   logic                   err_timeout;

   modport slave (
      input  req_valid, req_last, req_src, req_dst, req_data, fifo_fullp,
      output req_ready, fifo_writep, fifo_src, fifo_dst, fifo_data,
             grant_vld, grant_id, err_timeout
   );

   modport master (
      output req_valid, req_last, req_src, req_dst, req_data, fifo_fullp,
      input  req_ready, fifo_writep, fifo_src, fifo_dst, fifo_data,
             grant_vld, grant_id, err_timeout
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request bit at or above 'start', wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] start,
   output logic            any,
   output logic [ID_W-1:0] idx
);
   // One extra bit so start+offset never overflows before the modulo fold.
   localparam int            PW     = ID_W + 1;
   localparam logic [PW-1:0] NREQ_P = PW'(NREQ);

   logic [PW-1:0] pos_s;

   // Scan offsets from farthest to nearest so the nearest set bit is the one that sticks.
   always_comb begin
      any   = 1'b0;
      idx   = {ID_W{1'b0}};
      pos_s = {PW{1'b0}};
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos_s = {1'b0, start} + PW'(k);
         if (pos_s >= NREQ_P) begin
            pos_s = pos_s - NREQ_P;
         end else begin
            pos_s = pos_s;
         end
         if (req[pos_s[ID_W-1:0]]) begin
            any = 1'b1;
            idx = pos_s[ID_W-1:0];
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one packet FIFO among NREQ requesters.
// A grant is held for a whole packet (up to the 'last' beat); a watchdog
// reclaims the grant when the owner goes quiet for TIMEOUT cycles mid-packet.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int SRC_W   = DEF_SRC_W,
   parameter int DST_W   = DEF_DST_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rstp,
   fifo_wr_arbiter_if.slave bus
);
   localparam int              ID_W     = clog2(NREQ);
   localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ - 1);
   localparam logic [ID_W-1:0] ONE_ID   = ID_W'(1);

   arb_state_t      state_r, state_s;
   logic [ID_W-1:0] rr_ptr_r, rr_ptr_s;
   logic [ID_W-1:0] grant_id_r, grant_id_s;
   logic [7:0]      idle_cnt_r, idle_cnt_s;

   logic            pick_any_s;
   logic [ID_W-1:0] pick_idx_s;
   logic            own_valid_s;
   logic            own_last_s;
   logic            accept_s;
   logic [ID_W-1:0] next_ptr_s;

   logic [NREQ-1:0]   ready_s;
   logic              writep_s;
   logic              err_s;
   logic [SRC_W-1:0]  src_s;
   logic [DST_W-1:0]  dst_s;
   logic [DATA_W-1:0] data_s;

   rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req   (bus.req_valid),
      .start (rr_ptr_r),
      .any   (pick_any_s),
      .idx   (pick_idx_s)
   );

   // Owner's handshake bits and the pointer that follows it once its grant ends.
   assign own_valid_s = bus.req_valid[grant_id_r];
   assign own_last_s  = bus.req_last[grant_id_r];
   assign accept_s    = (state_r == BUSY) && own_valid_s && !bus.fifo_fullp;
   assign next_ptr_s  = (grant_id_r == LAST_ID) ? {ID_W{1'b0}} : (grant_id_r + ONE_ID);

   // Control registers: FSM state, round-robin pointer, granted id and watchdog count.
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         state_r    <= IDLE;
         rr_ptr_r   <= {ID_W{1'b0}};
         grant_id_r <= {ID_W{1'b0}};
         idle_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_s;
         rr_ptr_r   <= rr_ptr_s;
         grant_id_r <= grant_id_s;
         idle_cnt_r <= idle_cnt_s;
      end
   end

   // Next-state logic plus the combinational ready/write/timeout strobes.
   always_comb begin
      state_s    = state_r;
      rr_ptr_s   = rr_ptr_r;
      grant_id_s = grant_id_r;
      idle_cnt_s = idle_cnt_r;
      ready_s    = {NREQ{1'b0}};
      writep_s   = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (pick_any_s) begin
               grant_id_s = pick_idx_s;
               idle_cnt_s = 8'd0;
               state_s    = BUSY;
            end else begin
               state_s    = IDLE;
            end
         end
         BUSY: begin
            ready_s[grant_id_r] = !bus.fifo_fullp;
            writep_s            = accept_s;
            if (accept_s) begin
               if (own_last_s) begin
                  state_s  = IDLE;
                  rr_ptr_s = next_ptr_s;
               end else begin
                  idle_cnt_s = 8'd0;
               end
            end else if (!own_valid_s) begin
               // Only a silent owner ages the watchdog; a full-FIFO stall does not.
               if (idle_cnt_r == TMO_LAST) begin
                  err_s    = 1'b1;
                  state_s  = IDLE;
                  rr_ptr_s = next_ptr_s;
               end else begin
                  idle_cnt_s = idle_cnt_r + 8'd1;
               end
            end else begin
               idle_cnt_s = idle_cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Field mux toward the FIFO: follows the owner while busy, forced to zero when idle.
   always_comb begin
      src_s  = {SRC_W{1'b0}};
      dst_s  = {DST_W{1'b0}};
      data_s = {DATA_W{1'b0}};
      if (state_r == BUSY) begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_id_r == ID_W'(i)) begin
               src_s  = bus.req_src[i*SRC_W +: SRC_W];
               dst_s  = bus.req_dst[i*DST_W +: DST_W];
               data_s = bus.req_data[i*DATA_W +: DATA_W];
            end else begin
               src_s  = src_s;
            end
         end
      end else begin
         src_s  = {SRC_W{1'b0}};
      end
   end

   assign bus.req_ready   = ready_s;
   assign bus.fifo_writep = writep_s;
   assign bus.fifo_src    = src_s;
   assign bus.fifo_dst    = dst_s;
   assign bus.fifo_data   = data_s;
   assign bus.grant_vld   = (state_r == BUSY);
   assign bus.grant_id    = grant_id_r;
   assign bus.err_timeout = err_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a packet-level reference model.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int SRC_W   = 8;
   localparam int DST_W   = 8;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic [SRC_W-1:0]  src;
      logic [DST_W-1:0]  dst;
      logic [DATA_W-1:0] data;
      bit                last;
      int                gap;
   } beat_t;

   logic clk;
   logic rstp;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .SRC_W(SRC_W), .DST_W(DST_W), .DATA_W(DATA_W)) bus ();

   fifo_wr_arbiter #(
      .NREQ(NREQ), .SRC_W(SRC_W), .DST_W(DST_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .rstp (rstp),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests_run;
   int tests_failed;

   // Requester queues (what each requester still has to send) and the values driven now.
   beat_t             pq[NREQ][$];
   bit                s_valid[NREQ];
   bit                s_last[NREQ];
   logic [SRC_W-1:0]  s_src[NREQ];
   logic [DST_W-1:0]  s_dst[NREQ];
   logic [DATA_W-1:0] s_data[NREQ];
   bit                s_full;

   // Reference model: who owns the FIFO (-1 = nobody), rotation start, silence count.
   int m_owner, m_last, m_ptr, m_quiet, n_timeouts, err_seen;
   int                grant_log[$];
   logic [DATA_W-1:0] data_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_quiet = 0;
   endtask

   function automatic int queued();
      int n;
      n = 0;
      for (int i = 0; i < NREQ; i++) n += pq[i].size();
      return n;
   endfunction

   task automatic add_beat(input int r, input logic [DATA_W-1:0] d, input bit l, input int gap);
      beat_t b;
      b.src  = SRC_W'(8'hA0 + r);
      b.dst  = DST_W'($urandom);
      b.data = d;
      b.last = l;
      b.gap  = gap;
      pq[r].push_back(b);
   endtask

   task automatic add_pkt(input int r, input int n, input logic [DATA_W-1:0] base);
      for (int k = 0; k < n; k++) add_beat(r, base * DATA_W'(k + 1), (k == n - 1), 0);
   endtask

   // Put each requester's head-of-queue beat on the bus (or nothing while it is pausing).
   task automatic present();
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0 && pq[i][0].gap == 0) begin
            s_valid[i] = 1'b1;
            s_last[i]  = pq[i][0].last;
            s_src[i]   = pq[i][0].src;
            s_dst[i]   = pq[i][0].dst;
            s_data[i]  = pq[i][0].data;
         end else begin
            s_valid[i] = 1'b0;
            s_last[i]  = 1'($urandom);
         end
         bus.req_valid[i] = s_valid[i];
         bus.req_last[i]  = s_last[i];
         bus.req_src[i*SRC_W +: SRC_W]    = s_src[i];
         bus.req_dst[i*DST_W +: DST_W]    = s_dst[i];
         bus.req_data[i*DATA_W +: DATA_W] = s_data[i];
      end
      bus.fifo_fullp = s_full;
   endtask

   // One clock: drive, check all outputs against the model, advance model and queues.
   task automatic cycle();
      logic [NREQ-1:0]   e_ready;
      logic              e_wr, e_err;
      logic [SRC_W-1:0]  e_src;
      logic [DST_W-1:0]  e_dst;
      logic [DATA_W-1:0] e_data;
      bit                acc[NREQ];
      int                g, cand;
      present();
      #1;
      e_ready = '0; e_wr = 1'b0; e_err = 1'b0;
      e_src = '0; e_dst = '0; e_data = '0;
      g = m_owner;
      if (g >= 0) begin
         e_ready[g] = !s_full;
         e_wr   = s_valid[g] && !s_full;
         e_src  = s_src[g];
         e_dst  = s_dst[g];
         e_data = s_data[g];
         e_err  = !s_valid[g] && (m_quiet == TIMEOUT - 1);
      end
      chk("req_ready",   64'(bus.req_ready),   64'(e_ready));
      chk("fifo_writep", 64'(bus.fifo_writep), 64'(e_wr));
      chk("fifo_src",    64'(bus.fifo_src),    64'(e_src));
      chk("fifo_dst",    64'(bus.fifo_dst),    64'(e_dst));
      chk("fifo_data",   64'(bus.fifo_data),   64'(e_data));
      chk("grant_vld",   64'(bus.grant_vld),   64'(g >= 0));
      chk("grant_id",    64'(bus.grant_id),    64'(m_last));
      chk("err_timeout", 64'(bus.err_timeout), 64'(e_err));
      err_seen += int'(bus.err_timeout);
      for (int i = 0; i < NREQ; i++) acc[i] = e_ready[i] && s_valid[i];
      if (rstp) begin
         model_reset();
      end else if (g < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (m_owner < 0 && s_valid[cand]) begin
               m_owner = cand;
               m_last  = cand;
               m_quiet = 0;
               grant_log.push_back(cand);
            end
         end
      end else if (e_wr) begin
         data_log.push_back(s_data[g]);
         if (s_last[g]) begin
            m_owner = -1;
            m_ptr   = (g + 1) % NREQ;
         end else begin
            m_quiet = 0;
         end
      end else if (!s_valid[g]) begin
         if (e_err) begin
            m_owner = -1;
            m_ptr   = (g + 1) % NREQ;
            n_timeouts++;
         end else begin
            m_quiet++;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) pq[i].pop_front();
         else if (pq[i].size() > 0 && pq[i][0].gap > 0) pq[i][0].gap = pq[i][0].gap - 1;
      end
      @(negedge clk);
   endtask

   task automatic drain(input string tag, input int budget, output int used);
      used = 0;
      while ((queued() > 0 || m_owner >= 0) && used < budget) begin
         cycle();
         used++;
      end
      chk(tag, 64'(used < budget), 64'(1));
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) pq[i].delete();
      rstp = 1'b1;
      model_reset();
      cycle();
      cycle();
      rstp = 1'b0;
   endtask

   int used;
   int to_before;

   initial begin
      tests_run = 0; tests_failed = 0;
      n_timeouts = 0; err_seen = 0;
      s_full = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         s_valid[i] = 1'b0; s_last[i] = 1'b0;
         s_src[i] = '0; s_dst[i] = '0; s_data[i] = '0;
      end
      model_reset();
      rstp = 1'b1;
      present();
      #1;
      chk("reset_ready",  64'(bus.req_ready),   64'(0));
      chk("reset_write",  64'(bus.fifo_writep), 64'(0));
      chk("reset_gvld",   64'(bus.grant_vld),   64'(0));
      chk("reset_gid",    64'(bus.grant_id),    64'(0));
      chk("reset_data",   64'(bus.fifo_data),   64'(0));
      @(negedge clk);
      do_reset();

      // Three-beat packet from requester 0: grant next cycle, then one beat per cycle.
      data_log.delete(); grant_log.delete();
      add_pkt(0, 3, 32'h11);
      drain("t1_drain", 20, used);
      chk("t1_cycles", 64'(used), 64'(4));
      chk("t1_grant", 64'(grant_log[0]), 64'(0));
      chk("t1_nbeats", 64'(data_log.size()), 64'(3));
      chk("t1_beat0", 64'(data_log[0]), 64'(32'h11));
      chk("t1_beat1", 64'(data_log[1]), 64'(32'h22));
      chk("t1_beat2", 64'(data_log[2]), 64'(32'h33));
      chk("t1_gvld_after", 64'(bus.grant_vld), 64'(0));

      // All requesters with back-to-back single-beat packets: strict rotation, one bubble each.
      do_reset();
      grant_log.delete();
      for (int r = 0; r < NREQ; r++) begin
         add_pkt(r, 1, 32'h100 + r);
         add_pkt(r, 1, 32'h200 + r);
      end
      drain("t2_drain", 60, used);
      chk("t2_cycles", 64'(used), 64'(16));
      for (int k = 0; k < 8; k++) chk("t2_order", 64'(grant_log[k]), 64'(k % NREQ));

      // Requester 2 stalled by a full FIFO for longer than TIMEOUT: no watchdog release.
      data_log.delete();
      to_before = n_timeouts;
      add_pkt(2, 4, 32'hC0DE);
      cycle();
      cycle();
      s_full = 1'b1;
      for (int k = 0; k < 20; k++) cycle();
      chk("t3_stall_write", 64'(bus.fifo_writep), 64'(0));
      chk("t3_no_timeout", 64'(n_timeouts - to_before), 64'(0));
      chk("t3_one_beat", 64'(data_log.size()), 64'(1));
      s_full = 1'b0;
      drain("t3_drain", 20, used);
      chk("t3_resume_cycles", 64'(used), 64'(3));
      chk("t3_nbeats", 64'(data_log.size()), 64'(4));

      // Requester 1 goes silent mid-packet: watchdog fires once, requester 3 gets the grant.
      data_log.delete(); grant_log.delete();
      to_before = n_timeouts; err_seen = 0;
      add_beat(1, 32'hA1, 1'b0, 0);
      add_beat(1, 32'hA2, 1'b0, 0);
      add_beat(1, 32'hA3, 1'b1, 30);
      add_beat(3, 32'hD3, 1'b1, 4);
      for (int k = 0; k < 19; k++) cycle();
      chk("t4_err_pulse_at16", 64'(bus.err_timeout), 64'(0));
      chk("t4_err_count", 64'(err_seen), 64'(1));
      drain("t4_drain", 100, used);
      chk("t4_timeouts", 64'(n_timeouts - to_before), 64'(1));
      chk("t4_grant0", 64'(grant_log[0]), 64'(1));
      chk("t4_grant1", 64'(grant_log[1]), 64'(3));
      chk("t4_grant2", 64'(grant_log[2]), 64'(1));
      chk("t4_after_to", 64'(data_log[2]), 64'(32'hD3));

      // Asynchronous reset while requester 0 offers beat 2 of 4.
      add_pkt(0, 4, 32'h50);
      cycle();
      cycle();
      present();
      #2;
      chk("t5_pre_write", 64'(bus.fifo_writep), 64'(1));
      rstp = 1'b1;
      #1;
      chk("t5_rst_ready", 64'(bus.req_ready),   64'(0));
      chk("t5_rst_write", 64'(bus.fifo_writep), 64'(0));
      chk("t5_rst_src",   64'(bus.fifo_src),    64'(0));
      chk("t5_rst_dst",   64'(bus.fifo_dst),    64'(0));
      chk("t5_rst_data",  64'(bus.fifo_data),   64'(0));
      chk("t5_rst_gvld",  64'(bus.grant_vld),   64'(0));
      chk("t5_rst_err",   64'(bus.err_timeout), 64'(0));
      for (int i = 0; i < NREQ; i++) pq[i].delete();
      model_reset();
      @(negedge clk);
      cycle();
      rstp = 1'b0;
      grant_log.delete();
      add_pkt(0, 1, 32'hE0);
      add_pkt(3, 1, 32'hE3);
      drain("t5_drain", 20, used);
      chk("t5_first", 64'(grant_log[0]), 64'(0));
      chk("t5_second", 64'(grant_log[1]), 64'(3));

      // Requester 1 finishes, then 0 and 3 compete: pointer sits at 2, so 3 wins.
      add_pkt(1, 2, 32'h61);
      drain("t6_drain_a", 20, used);
      grant_log.delete();
      add_pkt(0, 1, 32'h70);
      add_pkt(3, 1, 32'h73);
      drain("t6_drain_b", 20, used);
      chk("t6_first", 64'(grant_log[0]), 64'(3));
      chk("t6_second", 64'(grant_log[1]), 64'(0));

      // Random traffic: variable packet lengths, pauses (some long enough to time out), full.
      for (int c = 0; c < 1500; c++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (pq[r].size() == 0 && $urandom_range(0, 3) == 0) begin
               int n, sel, gap;
               n = int'($urandom_range(1, 4));
               for (int k = 0; k < n; k++) begin
                  sel = int'($urandom_range(0, 9));
                  if (k == 0) gap = int'($urandom_range(0, 3));
                  else if (sel == 0) gap = int'($urandom_range(10, 24));
                  else if (sel < 3) gap = int'($urandom_range(1, 3));
                  else gap = 0;
                  add_beat(r, DATA_W'($urandom), (k == n - 1), gap);
               end
            end
         end
         s_full = ($urandom_range(0, 4) == 0);
         cycle();
      end
      s_full = 1'b0;
      drain("rand_drain", 2000, used);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous packet FIFO (8-bit src, 8-bit dst, 32-bit data per entry) among NREQ requesters. It grants one requester at a time for a whole packet, terminated by a `last` beat. It forwards accepted beats onto the FIFO write port, honouring the FIFO full flag. A watchdog reclaims the grant from a requester that stalls mid-packet.

## Interface
- NREQ, 4, number of requesters (2..8)
- SRC_W, 8, source field width
- DST_W, 8, destination field width
- DATA_W, 32, data field width
- TIMEOUT, 16, consecutive idle cycles mid-packet before forced release (1..255)

- clk  in  1  clock
- rstp  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  per-requester final beat of packet
- req_src  in  NREQ*SRC_W  requester i at [i*SRC_W +: SRC_W]
- req_dst  in  NREQ*DST_W  requester i at [i*DST_W +: DST_W]
- req_data  in  NREQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  beat accepted when valid&ready; one-hot or zero
- fifo_fullp  in  1  FIFO full flag
- fifo_writep  out  1  FIFO write strobe
- fifo_src  out  SRC_W  to FIFO src_in
- fifo_dst  out  DST_W  to FIFO dst_in
- fifo_data  out  DATA_W  to FIFO data_in
- grant_vld  out  1  a requester currently holds the grant
- grant_id  out  clog2(NREQ)  current/last granted requester
- err_timeout  out  1  one-cycle pulse on watchdog release

## Operation
- FSM states: IDLE, BUSY.
- IDLE
  - If any req_valid is set, select the first set bit searching upward (with wrap) from rr_ptr.
  - Register grant_id to that requester, set grant_vld=1, clear idle_cnt, go to BUSY.
  - If no req_valid is set, stay in IDLE.
- BUSY, with g = grant_id
  - req_ready[g] = !fifo_fullp; all other ready bits are 0.
  - fifo_writep = req_valid[g] & !fifo_fullp.
  - fifo_src/dst/data = requester g's fields (combinational mux). The mux still selects g when fifo_writep=0.
  - On an accepted beat with req_last[g]=1: go to IDLE, set rr_ptr = g+1 mod NREQ, clear grant_vld.
  - On an accepted beat without last: clear idle_cnt.
  - While req_valid[g]=0: increment idle_cnt. A fifo_fullp stall does not count.
  - When idle_cnt reaches TIMEOUT-1 with req_valid[g] still 0: pulse err_timeout, go to IDLE, set rr_ptr = g+1, clear grant_vld. The partial packet stays in the FIFO.
- In IDLE: req_ready=0, fifo_writep=0, and the field outputs are don't-care.
- A non-granted requester's valid/last are ignored. Requesters must hold valid and fields stable until accepted.
- Single-beat packet: valid and last both set on the first beat.
- rr_ptr wraps modulo NREQ. For non-power-of-2 NREQ, indices ≥ NREQ are never selected.

## Timing
- Reset values:
  - FSM=IDLE, rr_ptr=0, idle_cnt=0.
  - grant_vld=0, grant_id=0, err_timeout=0.
  - req_ready=0, fifo_writep=0, fifo_src/dst/data=0.
- Arbitration latency: valid asserted at cycle t gives grant registered at t+1. The earliest ready/write is at cycle t+1.
- Throughput: 1 beat/cycle inside a packet. There is one IDLE bubble cycle between packets.
- Full handling: fifo_fullp is sampled in the same cycle. No beat is offered to the FIFO while full, so there is no overflow.
- Reset mid-packet: immediate return to IDLE, all outputs go to reset values, and the packet is truncated.
- err_timeout is high for exactly one cycle, in the cycle the FSM leaves BUSY.

## Structure
- Shared package `fifo_arb_pkg`:
  - state enum {IDLE, BUSY}
  - default widths SRC_W/DST_W/DATA_W
  - id-width function clog2.
- One sub-module `rr_pick`: combinational rotate-priority encoder.
  - Inputs: req vector and start pointer.
  - Outputs: any and index.
- All other logic is in the top level. Only the FSM, rr_ptr, grant and idle_cnt are registered; the ready/write path is combinational from grant and full.

## Test plan
- Reset, then req_valid=4'b0001 with 3 beats (last on beat 3), data 0x11,0x22,0x33 → grant at +1 cycle; fifo_writep high 3 cycles carrying 0x11,0x22,0x33; grant_vld falls after the last beat.
- All 4 requesters send continuous 1-beat packets → grant order 0,1,2,3,0 with one bubble between packets; no requester is starved.
- Requester 2 mid-packet with fifo_fullp held 1 for 10 cycles → req_ready[2]=0 and fifo_writep=0 for 10 cycles; no timeout; transfer resumes when full drops.
- Requester 1 drops valid after 2 beats for TIMEOUT=16 cycles → err_timeout pulses once on cycle 16; requester 3 (valid) is granted next.
- Requester 0 sending beat 2 of 4, rstp asserted asynchronously → all outputs go to 0 immediately; after reset, the next grant goes to requester 0 (rr_ptr=0).
- Requester 1 finishes, then requesters 0 and 3 are both valid → rr_ptr=2, so requester 3 is granted before 0.
